// File: rtl/meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding, default
// counter width and averaging depth.
package meter_pkg;

  localparam int DEF_CNT_W = 13;
  localparam int AVG_LOG2  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_RISE = 2'b01,
    ST_MEASURE   = 2'b10
  } meter_state_e;

endpackage

// File: rtl/sig_edge_sync.sv
// Synchronizer chain plus edge detector for a slow asynchronous input.
// rise_det/fall_det are registered single-cycle pulses.
module sig_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_det,
  output logic fall_det
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_det = rise_q;
  assign fall_det = fall_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Define PERIOD_AVG_EN to report the floor average of 4 consecutive periods.
module clock_period_meter
  import meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overflow,
  output meter_state_e     dbg_state
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Last count that still leaves room for cnt+1 without wrapping.
  localparam logic [CNT_W-1:0] CNT_LIMIT = ~CNT_W'(1);

  logic rise_det, fall_det;

  sig_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .rise_det (rise_det),
    .fall_det (fall_det)
  );

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             take_rise, clear_avg;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_period, rpt_high;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    ovf_d     = ovf_q;
    take_rise = 1'b0;
    clear_avg = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      clear_avg = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_RISE;
          cnt_d   = '0;
        end
        ST_WAIT_RISE: begin
          if (rise_det) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
          end
        end
        ST_MEASURE: begin
          cnt_d = cnt_inc;
          if (fall_det) hi_cap_d = cnt_inc;
          // A rise on the threshold cycle still counts as a valid period.
          if (rise_det) begin
            cnt_d     = '0;
            ovf_d     = 1'b0;
            take_rise = 1'b1;
          end else if (cnt_q == CNT_LIMIT) begin
            state_d   = ST_WAIT_RISE;
            cnt_d     = '0;
            ovf_d     = 1'b1;
            clear_avg = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef PERIOD_AVG_EN
  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] AVG_ONE = AVG_LOG2'(1);

  logic [ACC_W-1:0]    acc_p_q, acc_p_d, acc_h_q, acc_h_d, p_sum, h_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;

  assign p_sum = acc_p_q + {{AVG_LOG2{1'b0}}, cnt_inc};
  assign h_sum = acc_h_q + {{AVG_LOG2{1'b0}}, hi_cap_q};

  always_comb begin
    acc_p_d    = acc_p_q;
    acc_h_d    = acc_h_q;
    avg_cnt_d  = avg_cnt_q;
    rpt_valid  = 1'b0;
    rpt_period = p_sum[ACC_W-1:AVG_LOG2];
    rpt_high   = h_sum[ACC_W-1:AVG_LOG2];
    if (clear_avg) begin
      acc_p_d   = '0;
      acc_h_d   = '0;
      avg_cnt_d = '0;
    end else if (take_rise) begin
      if (avg_cnt_q == '1) begin
        rpt_valid = 1'b1;
        acc_p_d   = '0;
        acc_h_d   = '0;
        avg_cnt_d = '0;
      end else begin
        acc_p_d   = p_sum;
        acc_h_d   = h_sum;
        avg_cnt_d = avg_cnt_q + AVG_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p_q   <= '0;
      acc_h_q   <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_p_q   <= acc_p_d;
      acc_h_q   <= acc_h_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  always_comb begin
    rpt_valid  = take_rise;
    rpt_period = cnt_inc;
    rpt_high   = hi_cap_q;
  end
`endif

  always_comb begin
    valid_d  = rpt_valid;
    period_d = rpt_valid ? rpt_period : period_q;
    high_d   = rpt_valid ? rpt_high : high_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_cap_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_cap_q <= hi_cap_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: timestamp-based reference model,
// table-driven divider ratios, and hand sequences for reset/enable/overflow.
module tb_clock_period_meter;
  import meter_pkg::*;

  localparam int W     = 13;
  localparam int SS    = 2;
  localparam int LIMIT = (1 << W) - 1;
`ifdef PERIOD_AVG_EN
  localparam int RPR = 4;
`else
  localparam int RPR = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         meas_valid, overflow;
  meter_state_e dbg_state;

  always #5 clk = ~clk;

  clock_period_meter #(.CNT_W(W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: works on edge timestamps of the synchronized waveform.
  logic [SS+2:0] m_shist;
  int  m_f, m_ref, m_hi, m_period, m_high, m_valid, m_ovf;
  bit  m_running, m_have_ref;
  int  pq[$], hq[$];

  function automatic void model_reset();
    m_shist = '0; m_f = 0; m_ref = 0; m_hi = 0;
    m_period = 0; m_high = 0; m_valid = 0; m_ovf = 0;
    m_running = 0; m_have_ref = 0;
    pq.delete(); hq.delete();
  endfunction

  function automatic void model_step();
    bit rise, fall;
    int age, prev_hi, ps, hs;
    m_shist = {m_shist[SS+1:0], sig_in};
    m_f++;
    rise = m_shist[SS+1] & ~m_shist[SS+2];
    fall = ~m_shist[SS+1] & m_shist[SS+2];
    m_valid = 0;
    if (!enable) begin
      m_running = 0; m_have_ref = 0;
      pq.delete(); hq.delete();
    end else if (!m_running) begin
      m_running = 1;
    end else if (!m_have_ref) begin
      if (rise) begin m_have_ref = 1; m_ref = m_f; end
    end else begin
      age = m_f - m_ref;
      prev_hi = m_hi;
      if (fall) m_hi = age;
      if (rise) begin
        m_ovf = 0;
        m_ref = m_f;
        pq.push_back(age);
        hq.push_back(prev_hi);
        if (pq.size() == RPR) begin
          ps = 0; hs = 0;
          foreach (pq[i]) begin ps += pq[i]; hs += hq[i]; end
          m_period = ps / RPR;
          m_high = hs / RPR;
          m_valid = 1;
          pq.delete(); hq.delete();
        end
      end else if (age == LIMIT) begin
        m_ovf = 1; m_have_ref = 0;
        pq.delete(); hq.delete();
      end
    end
  endfunction

  function automatic int model_state();
    if (!m_running) return int'(ST_IDLE);
    if (!m_have_ref) return int'(ST_WAIT_RISE);
    return int'(ST_MEASURE);
  endfunction

  task automatic tick(input logic s, input logic en);
    sig_in = s;
    enable = en;
    @(posedge clk);
    model_step();
    #1;
    check("period", period, m_period);
    check("high_time", high_time, m_high);
    check("meas_valid", meas_valid, m_valid);
    check("overflow", overflow, m_ovf);
    check("state", int'(dbg_state), model_state());
  endtask

  task automatic run_wave(input int m, input int h, input int n);
    for (int p = 0; p < n; p++)
      for (int k = 0; k < m; k++) tick(k < h, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  typedef struct {
    int m;
    int h;
    int nper;
    int exp_p;
    int exp_h;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, first_valid, m, h, n, dlen;
    vecs[0] = '{m: 6,   h: 3,  nper: 12, exp_p: 6,   exp_h: 3};
    vecs[1] = '{m: 7,   h: 3,  nper: 12, exp_p: 7,   exp_h: 3};
    vecs[2] = '{m: 2,   h: 1,  nper: 12, exp_p: 2,   exp_h: 1};
    vecs[3] = '{m: 33,  h: 1,  nper: 12, exp_p: 33,  exp_h: 1};
    vecs[4] = '{m: 100, h: 50, nper: 12, exp_p: 100, exp_h: 50};

    // Power-on reset
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Divider ratios
    foreach (vecs[i]) begin
      run_wave(vecs[i].m, vecs[i].h, vecs[i].nper);
      check($sformatf("vec%0d_period", i), period, vecs[i].exp_p);
      check($sformatf("vec%0d_high", i), high_time, vecs[i].exp_h);
      check($sformatf("vec%0d_ovf", i), overflow, 0);
    end

    // Enable dropped for 3 cycles inside a period
    run_wave(10, 5, 12);
    for (int k = 0; k < 10; k++) tick(k < 5, !(k >= 2 && k < 5));
    check("en_hold_period", period, 10);
    check("en_hold_high", high_time, 5);
    run_wave(10, 5, 12);
    check("en_after_period", period, 10);
    check("en_after_high", high_time, 5);

    // Reset halfway through a period, then first-result latency
    run_wave(12, 6, 12);
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    first_valid = -1;
    for (int t = 0; t < 8 * (RPR + 1) + 8; t++) begin
      tick((t % 8) < 4, 1'b1);
      if (meas_valid && first_valid < 0) first_valid = t;
    end
    check("first_valid_tick", first_valid, 8 * RPR + SS + 1);
    check("latency_period", period, 8);
    check("latency_high", high_time, 4);

    // Stuck input after one rise
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b1);
    nv = 0;
    for (int k = 0; k < 8200; k++) begin
      tick(1'b0, 1'b1);
      if (meas_valid) nv++;
    end
    check("stuck_overflow", overflow, 1);
    check("stuck_no_valid", nv, 0);
    run_wave(100, 50, 6);
    check("recover_overflow", overflow, 0);
    check("recover_period", period, 100);
    check("recover_high", high_time, 50);

    // Longest measurable period vs first overflowing one
    run_wave(LIMIT, 10, 3);
    check("limit_no_overflow", overflow, 0);
    run_wave(LIMIT + 1, 10, 2);
    check("limit_overflow", overflow, 1);

    // Random waveforms with occasional enable drops
    for (int seg = 0; seg < 25; seg++) begin
      m = $urandom_range(50, 2);
      h = $urandom_range(m - 1, 1);
      n = $urandom_range(6, 1);
      dlen = ($urandom_range(3, 0) == 0) ? $urandom_range(5, 1) : 0;
      for (int p = 0; p < n; p++)
        for (int k = 0; k < m; k++)
          tick(k < h, !(p == 0 && k < dlen));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, free-running square wave (typically the divided ADC clock or the mains zero-cross comparator output) in units of the system clock `clk`. It performs the inverse of the integer clock divider: given the divided waveform, it recovers the division ratio M and the high-phase length. It sits beside the divider in the metering front end for self-check and line-frequency measurement.

## Interface
- `CNT_W`, 13: width of the period and high-time counters; matches the divider ratio width.
- `SYNC_STAGES`, 2: number of synchronizer flops on `sig_in`; minimum 2.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low; clock `clk`.
- `enable` input 1: measurement enable; low forces IDLE.
- `sig_in` input 1: asynchronous square wave under measurement.
- `period` output CNT_W: last measured rising-to-rising interval, in clk cycles.
- `high_time` output CNT_W: last measured rising-to-falling interval, in clk cycles.
- `meas_valid` output 1: one-cycle pulse; `period`/`high_time` were updated this cycle.
- `overflow` output 1: sticky flag; no rising edge arrived within 2^CNT_W−1 cycles.

## Operation
- `sig_in` passes through SYNC_STAGES flops plus one history flop. `rise_det`/`fall_det` are single-cycle pulses.
- State machine: IDLE → WAIT_RISE → MEASURE.
  - IDLE: `cnt`=0. On `enable`=1, go to WAIT_RISE.
  - WAIT_RISE: discard the partial period. On `rise_det`, `cnt`←0 and go to MEASURE.
  - MEASURE: `cnt` increments each cycle.
    - On `fall_det`: latch `hi_cap`←`cnt`+1.
    - On `rise_det`: `period`←`cnt`+1, `high_time`←`hi_cap`, `meas_valid` pulses, `overflow`←0, `cnt`←0, and the state stays in MEASURE.
- Widths: `cnt` is CNT_W bits. The +1 is computed at CNT_W bits and is guaranteed not to wrap because of the overflow rule.
- Overflow: if `cnt` reaches 2^CNT_W−2 without a `rise_det`:
  - set `overflow`=1;
  - go to WAIT_RISE;
  - no `meas_valid`; `period`/`high_time` hold their values.
- No falling edge within a period (degenerate input): `high_time` reports the previous `hi_cap`; no error flag.
- `rise_det` and overflow threshold in the same cycle: the rise wins and the measurement is valid.
- `enable` deasserted in any state:
  - next state is IDLE, `cnt`=0, `meas_valid`=0;
  - `period`/`high_time` hold; `overflow` holds.
- Re-enable always restarts at WAIT_RISE, so the first `meas_valid` comes on the second rising edge.

## Timing
- Reset values:
  - `period`=0, `high_time`=0, `meas_valid`=0, `overflow`=0;
  - state IDLE, `cnt`=0, synchronizer flops 0.
- Edge latency: a `sig_in` edge produces `rise_det` SYNC_STAGES+1 clk edges later.
- Output latency: `meas_valid`, `period` and `high_time` are registered and update 1 cycle after the `rise_det` cycle. Total is SYNC_STAGES+2 cycles from the `sig_in` rise.
- Resolution is ±1 clk for asynchronous input. For input derived synchronously from `clk` the result is exact.
- Reset mid-measurement: all state is cleared immediately, and the partial measurement is discarded.

## Configuration
- `PERIOD_AVG_EN` defined:
  - accumulate 4 consecutive periods and 4 high times in CNT_W+2-bit accumulators;
  - report the sums >>2 (floor);
  - `meas_valid` pulses once per 4 periods;
  - overflow, disable or reset clears the accumulators and the 4-count.
- Undefined: one result per period, as above.

## Structure
- Shared package `meter_pkg`:
  - state encoding constants (IDLE=2'b00, WAIT_RISE=2'b01, MEASURE=2'b10);
  - default CNT_W=13;
  - averaging depth constant AVG_LOG2=2.
- Sub-module `sig_edge_sync`: the synchronizer chain plus edge detector (`sig_in` → `rise_det`, `fall_det`). It is reused for the zero-cross input elsewhere.

## Test plan
- Even ratio: drive `sig_in` from the integer divider with M=6, `enable`=1 → from the second rise onward, `period`=6, `high_time`=3, `meas_valid` every 6 cycles.
- Odd ratio: divider with M=7 → `period`=7, `high_time`=3 (low phase 4), steady.
- Stuck input: `sig_in`=0 after one rise → `overflow`=1 after 8190 cycles with no `meas_valid`. A later square wave of period 100 → `overflow` clears with `period`=100.
- Reset mid-measure: assert `rst_n`=0 halfway through a period → all outputs 0 immediately. After release, the first `meas_valid` comes on the second rise.
- Enable toggle: drop `enable` for 3 cycles during MEASURE → no `meas_valid` for the interrupted period, outputs hold, the next valid result follows two rises later.
- `PERIOD_AVG_EN`: periods 6,7,6,7 → `period`=6 (26>>2); one `meas_valid` per 4 periods.
